gsim_mem_fetch: RTL and testbench

- Upstream feeder for the GSIM solver core.
- On a start pulse it walks the matrix memory for i_matrix_num matrices and issues 256-bit word reads under the i_mem_rrdy handshake.
- Returned words are buffered in a credit-protected FIFO and presented to the core as a ready/valid row stream, tagged with matrix index, row index and a last flag.
- Decouples solver compute stalls from memory latency and read-ready backpressure.

---
 rtl/gsim_pkg.sv | 22 ++
 rtl/gsim_fetch_fifo.sv | 63 ++++++
 rtl/gsim_mem_fetch.sv | 189 ++++++++++++++++++
 tb/tb_gsim_mem_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared constants, FSM state and row tag type for the GSIM fetch path
package gsim_pkg;

    localparam int WORDS_PER_MAT = 17;   // rows 0..15 hold A, row 16 holds b
    localparam int ROWS_A        = 16;
    localparam int ADDR_W        = 10;
    localparam int DATA_W        = 256;
    localparam int FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] mat_idx;
        logic [4:0] row_idx;
        logic       last;
    } row_tag_t;

endpackage

// File: rtl/gsim_fetch_fifo.sv
// rtl/gsim_fetch_fifo.sv - synchronous row buffer FIFO with registered storage output
// Ports: clk, rst_n (async active-low); push/push_data write side;
//        pop/pop_data read side (pop_data shows the head entry);
//        full, empty, count status.
module gsim_fetch_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_V);
    assign empty    = (count == '0);
    // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gsim_mem_fetch.sv
// rtl/gsim_mem_fetch.sv - matrix memory walker feeding tagged rows to the GSIM solver core
// Ports: i_clk, i_rst_n (async active-low); i_start/i_matrix_num launch a run;
//        o_busy/o_done run status; o_mem_rreq/o_mem_addr/i_mem_rrdy read request;
//        i_mem_dout/i_mem_dout_vld in-order read return;
//        o_row_vld/o_row_data/o_row_idx/o_mat_idx/o_row_last/i_row_rdy row stream.
module gsim_mem_fetch
    import gsim_pkg::*;
#(
    parameter int WORDS_PER_MAT = gsim_pkg::WORDS_PER_MAT,
    parameter int FIFO_DEPTH    = gsim_pkg::FIFO_DEPTH,
    parameter int ADDR_W        = gsim_pkg::ADDR_W,
    parameter int DATA_W        = gsim_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [4:0]        i_matrix_num,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rreq,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_rrdy,
    input  logic [DATA_W-1:0] i_mem_dout,
    input  logic              i_mem_dout_vld,
    output logic              o_row_vld,
    output logic [DATA_W-1:0] o_row_data,
    output logic [4:0]        o_row_idx,
    output logic [4:0]        o_mat_idx,
    output logic              o_row_last,
    input  logic              i_row_rdy
);

    localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [4:0]       LAST_ROW = 5'(WORDS_PER_MAT - 1);
    localparam logic [CNT_W:0]   DEPTH_V  = (CNT_W + 1)'(FIFO_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic              done_q;
    logic              done_nxt;
    logic              start_ok;

    logic [4:0]        num_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        req_row;
    logic [4:0]        req_mat;
    logic [4:0]        row_idx;
    logic [4:0]        mat_idx;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    logic              credit_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic              last_req;
    row_tag_t          tag;

    // Every issued read owns a FIFO slot until it is popped, so capping
    // in-flight plus buffered words at the depth makes overflow impossible.
    assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_V;
    assign o_mem_rreq = (state == ST_FETCH) && credit_ok;
    assign o_mem_addr = addr_q;
    assign accept     = o_mem_rreq && i_mem_rrdy;
    // Returns with nothing outstanding are leftovers from before a reset.
    assign push       = i_mem_dout_vld && (outstanding != '0);
    assign pop        = o_row_vld && i_row_rdy;
    assign last_req   = (req_mat == num_q - 5'd1) && (req_row == LAST_ROW);

    assign tag.mat_idx = mat_idx;
    assign tag.row_idx = row_idx;
    assign tag.last    = (mat_idx == num_q - 5'd1) && (row_idx == LAST_ROW);

    assign o_row_vld  = !fifo_empty;
    assign o_row_data = o_row_vld ? fifo_dout : '0;
    assign o_row_idx  = o_row_vld ? tag.row_idx : '0;
    assign o_mat_idx  = o_row_vld ? tag.mat_idx : '0;
    assign o_row_last = o_row_vld && tag.last;
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = done_q;

    gsim_fetch_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data (i_mem_dout),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        start_ok  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_matrix_num != 5'd0) begin
                        start_ok  = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (accept && last_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && tag.last) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_q   <= '0;
            addr_q  <= '0;
            req_row <= '0;
            req_mat <= '0;
            row_idx <= '0;
            mat_idx <= '0;
        end else if (start_ok) begin
            num_q   <= i_matrix_num;
            addr_q  <= '0;
            req_row <= '0;
            req_mat <= '0;
            row_idx <= '0;
            mat_idx <= '0;
        end else begin
            // Linear address equals request index: m*WORDS_PER_MAT + r.
            if (accept) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (req_row == LAST_ROW) begin
                    req_row <= '0;
                    req_mat <= req_mat + 5'd1;
                end else begin
                    req_row <= req_row + 5'd1;
                end
            end
            if (pop) begin
                if (row_idx == LAST_ROW) begin
                    row_idx <= '0;
                    mat_idx <= mat_idx + 5'd1;
                end else begin
                    row_idx <= row_idx + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding <= '0;
        end else begin
            case ({accept, push})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_mem_fetch.sv
// tb/tb_gsim_mem_fetch.sv - scoreboard bench for gsim_mem_fetch
module tb_gsim_mem_fetch;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_start;
    logic [4:0]   i_matrix_num;
    logic         o_busy;
    logic         o_done;
    logic         o_mem_rreq;
    logic [9:0]   o_mem_addr;
    logic         i_mem_rrdy = 1'b1;
    logic [255:0] i_mem_dout = '0;
    logic         i_mem_dout_vld = 1'b0;
    logic         o_row_vld;
    logic [255:0] o_row_data;
    logic [4:0]   o_row_idx;
    logic [4:0]   o_mat_idx;
    logic         o_row_last;
    logic         i_row_rdy;

    always #10 i_clk = ~i_clk;

    gsim_mem_fetch dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_matrix_num   (i_matrix_num),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_mem_rreq     (o_mem_rreq),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rrdy     (i_mem_rrdy),
        .i_mem_dout     (i_mem_dout),
        .i_mem_dout_vld (i_mem_dout_vld),
        .o_row_vld      (o_row_vld),
        .o_row_data     (o_row_data),
        .o_row_idx      (o_row_idx),
        .o_mat_idx      (o_mat_idx),
        .o_row_last     (o_row_last),
        .i_row_rdy      (i_row_rdy)
    );

    typedef struct {
        logic [255:0] data;
        logic [4:0]   mat;
        logic [4:0]   row;
        logic         last;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int acc_cnt   = 0;
    int pop_cnt   = 0;
    int done_cnt  = 0;
    int exp_addr  = 0;
    int last_addr = -1;

    logic [1:0]   lat    = 2'd1;
    bit           toggle = 1'b0;
    logic [3:0]   dl_v   = '0;
    logic [9:0]   dl_a [4];
    bit           hold_pend = 1'b0;
    logic [9:0]   held_addr = '0;
    bit           stall_pend = 1'b0;
    logic [255:0] stall_data = '0;
    logic [10:0]  stall_tag  = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] word_of(input int a);
        logic [15:0] x;
        x = 16'(a);
        return {8{x, x ^ 16'h5A5A}};
    endfunction

    // Memory model: rrdy pattern, in-order returns after lat cycles, address checks.
    always begin
        @(negedge i_clk);
        #1;
        dl_v    = {dl_v[2:0], 1'b0};
        dl_a[3] = dl_a[2];
        dl_a[2] = dl_a[1];
        dl_a[1] = dl_a[0];
        i_mem_rrdy = toggle ? ~i_mem_rrdy : 1'b1;
        if (i_rst_n) begin
            if (hold_pend) begin
                chk("rreq_hold", 256'(o_mem_rreq), 256'(1));
                chk("addr_hold", 256'(o_mem_addr), 256'(held_addr));
            end
            hold_pend = 1'b0;
            if (o_mem_rreq) begin
                chk("credit", 256'((acc_cnt - pop_cnt) < 4), 256'(1));
            end
            if (o_mem_rreq && i_mem_rrdy) begin
                chk("addr", 256'(o_mem_addr), 256'(exp_addr));
                exp_addr++;
                acc_cnt++;
                last_addr = int'(o_mem_addr);
                dl_v[0]   = 1'b1;
                dl_a[0]   = o_mem_addr;
            end else if (o_mem_rreq) begin
                hold_pend = 1'b1;
                held_addr = o_mem_addr;
            end
        end
        i_mem_dout_vld = dl_v[lat];
        i_mem_dout     = dl_v[lat] ? word_of(int'(dl_a[lat])) : '0;
    end

    // Row monitor: pops the scoreboard on every accepted row.
    always begin
        @(negedge i_clk);
        #1;
        if (i_rst_n) begin
            if (o_done) done_cnt++;
            if (stall_pend && o_row_vld) begin
                chk("row_stable_data", o_row_data, stall_data);
                chk("row_stable_tag", 256'({o_mat_idx, o_row_idx, o_row_last}), 256'(stall_tag));
            end
            stall_pend = 1'b0;
            if (o_row_vld && !i_row_rdy) begin
                stall_pend = 1'b1;
                stall_data = o_row_data;
                stall_tag  = {o_mat_idx, o_row_idx, o_row_last};
            end
            if (o_row_vld && i_row_rdy) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL row_unexpected: got mat %0d row %0d, expected no row", o_mat_idx, o_row_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("row_data", o_row_data, e.data);
                    chk("row_tag", 256'({o_mat_idx, o_row_idx, o_row_last}), 256'({e.mat, e.row, e.last}));
                end
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic clear_counts();
        acc_cnt   = 0;
        pop_cnt   = 0;
        done_cnt  = 0;
        exp_addr  = 0;
        last_addr = -1;
    endtask

    task automatic push_exp(input int num);
        for (int m = 0; m < num; m++) begin
            for (int r = 0; r < 17; r++) begin
                exp_t e;
                e.data = word_of(m * 17 + r);
                e.mat  = 5'(m);
                e.row  = 5'(r);
                e.last = (m == num - 1) && (r == 16);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_run(input int num);
        @(negedge i_clk);
        i_matrix_num = 5'(num);
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        #2;
        chk("busy_after_start", 256'(o_busy), 256'(1));
    endtask

    task automatic wait_done(input int budget, input int total);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge i_clk);
            #2;
            if (o_done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no o_done in %0d cycles, required a pulse", budget);
        end else begin
            chk("busy_at_done", 256'(o_busy), 256'(0));
        end
        @(negedge i_clk);
        #2;
        chk("done_one_cycle", 256'(o_done), 256'(0));
        chk("done_count", 256'(done_cnt), 256'(1));
        chk("rows_all_seen", 256'(exp_q.size()), 256'(0));
        chk("req_total", 256'(acc_cnt), 256'(total));
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_ctl"}, 256'({o_busy, o_done, o_mem_rreq, o_row_vld, o_row_last}), 256'(0));
        chk({nm, "_addr"}, 256'(o_mem_addr), 256'(0));
        chk({nm, "_data"}, o_row_data, 256'(0));
        chk({nm, "_tags"}, 256'({o_mat_idx, o_row_idx}), 256'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        bit hit;
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_matrix_num = 5'd0;
        i_row_rdy    = 1'b1;
        repeat (3) @(negedge i_clk);
        #2;
        chk_outputs_zero("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Three matrices, ideal memory and sink.
        clear_counts();
        push_exp(3);
        start_run(3);
        wait_done(400, 51);
        chk("final_addr_3", 256'(last_addr), 256'(50));

        // 31 matrices with the sink stalled for 20 cycles first.
        clear_counts();
        push_exp(31);
        i_row_rdy = 1'b0;
        start_run(31);
        repeat (20) @(negedge i_clk);
        #2;
        chk("stall_rreq_off", 256'(o_mem_rreq), 256'(0));
        chk("stall_inflight", 256'(acc_cnt), 256'(4));
        chk("stall_row_vld", 256'(o_row_vld), 256'(1));
        @(negedge i_clk);
        i_row_rdy = 1'b1;
        wait_done(2000, 527);
        chk("final_addr_31", 256'(last_addr), 256'(526));

        // Toggling read-ready with 3-cycle latency.
        @(negedge i_clk);
        lat    = 2'd3;
        toggle = 1'b1;
        clear_counts();
        push_exp(2);
        start_run(2);
        wait_done(1000, 34);
        @(negedge i_clk);
        toggle = 1'b0;
        repeat (4) @(negedge i_clk);

        // Zero matrices: immediate done, no requests.
        clear_counts();
        @(negedge i_clk);
        i_matrix_num = 5'd0;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        #2;
        chk("zero_done", 256'(o_done), 256'(1));
        chk("zero_busy", 256'(o_busy), 256'(0));
        repeat (5) @(negedge i_clk);
        #2;
        chk("zero_no_req", 256'(acc_cnt), 256'(0));
        chk("zero_done_once", 256'(done_cnt), 256'(1));

        // Reset mid-run around row 20, latency 3 so stale returns follow reset.
        clear_counts();
        push_exp(2);
        start_run(2);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge i_clk);
            #2;
            if (pop_cnt >= 20) hit = 1'b1;
        end
        chk("reach_row20", 256'(hit), 256'(1));
        @(negedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrun_reset");
        exp_q.delete();
        clear_counts();
        #1;
        i_rst_n = 1'b1;
        repeat (6) @(negedge i_clk);
        #2;
        chk("stale_dropped", 256'({o_row_vld, o_busy}), 256'(0));
        clear_counts();
        push_exp(1);
        start_run(1);
        wait_done(400, 17);
        chk("final_addr_after_reset", 256'(last_addr), 256'(16));
        @(negedge i_clk);
        lat = 2'd1;
        repeat (4) @(negedge i_clk);

        // Start re-pulsed during FETCH with a different count.
        clear_counts();
        push_exp(2);
        start_run(2);
        repeat (5) @(negedge i_clk);
        i_matrix_num = 5'd7;
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(400, 34);
        chk("final_addr_repulse", 256'(last_addr), 256'(33));

        repeat (3) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
